// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, op encoding and read latency for the multi-channel memory
package mem_pkg;
  localparam int NCH_DEF = 2;
  localparam int DW_DEF = 32;
  localparam int DEPTH_DEF = 64;
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ = 1'b0;
  localparam int RD_LAT = 1;
endpackage

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: round-robin arbiter, one-hot grant, pointer advances past the winner on accept
// Ports: clk, rst (async, active-high), req[NCH], accept (a grant was taken this cycle), gnt[NCH] one-hot or zero
module mem_rr_arb #(
  parameter int NCH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           accept,
  output logic [NCH-1:0] gnt
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  logic [PW-1:0] ptr, gidx;
  // Scan from the farthest candidate back to the pointer so the closest requester wins last.
  always_comb begin
    gnt = '0;
    gidx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NCH]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NCH] = 1'b1;
        gidx = PW'((int'(ptr) + k) % NCH);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (accept) ptr <= (int'(gidx) == NCH - 1) ? '0 : gidx + PW'(1);
  end
endmodule

// File: rtl/mem_multi_ch.sv
// mem_multi_ch: multi-channel word memory with round-robin access, byte-enabled writes, 1-cycle reads
// Ports: clk, rst (async, active-high); per channel valid/ready/wr_rd/addr/wdata/wstrb;
//   shared rdata with one-hot rvalid owner strobe; oob pulses for addr >= DEPTH.
// Optional MEM_PARITY_EN: per-word even parity, inj_perr input corrupts the stored parity of
//   the write accepted that cycle, perr output pulses with rvalid on a parity mismatch.
module mem_multi_ch
  import mem_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    valid,
  output logic [NCH-1:0]    ready,
  input  logic [NCH-1:0]    wr_rd,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  input  logic [NCH*DW/8-1:0] wstrb,
  output logic [DW-1:0]     rdata,
  output logic [NCH-1:0]    rvalid,
  output logic              oob
`ifdef MEM_PARITY_EN
  ,
  input  logic              inj_perr,
  output logic              perr
`endif
);
  localparam int NB = DW / 8;
  logic [NCH-1:0] gnt;
  logic acc, op, hit, wr_acc, rd_acc;
  logic [AW-1:0] a;
  logic [DW-1:0] d, nw;
  logic [NB-1:0] s;
  logic [DW-1:0] mem [DEPTH];
  mem_rr_arb #(.NCH(NCH)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(valid),
    .accept(acc),
    .gnt(gnt)
  );
  assign ready = rst ? '0 : gnt;
  assign acc = |(valid & ready);
  always_comb begin
    a = '0;
    op = OP_READ;
    d = '0;
    s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ready[i]) begin
        a = addr[i*AW +: AW];
        op = wr_rd[i];
        d = wdata[i*DW +: DW];
        s = wstrb[i*NB +: NB];
      end
    end
  end
  assign hit = int'(a) < DEPTH;
  assign wr_acc = acc && op == OP_WRITE && hit;
  assign rd_acc = acc && op == OP_READ;
  // Merged word: old contents with strobed bytes replaced.
  always_comb begin
    nw = hit ? mem[a] : '0;
    for (int b = 0; b < NB; b++) if (s[b]) nw[b*8 +: 8] = d[b*8 +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    else if (wr_acc) mem[a] <= nw;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= '0;
      rdata <= '0;
      oob <= 1'b0;
    end else begin
      rvalid <= rd_acc ? ready : '0;
      oob <= acc && !hit;
      if (rd_acc) rdata <= hit ? mem[a] : '0;
    end
  end
`ifdef MEM_PARITY_EN
  logic [DEPTH-1:0] par;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
      perr <= 1'b0;
    end else begin
      if (wr_acc && |s) par[a] <= ^nw ^ inj_perr;
      perr <= rd_acc && hit && ((^mem[a]) != par[a]);
    end
  end
`endif
endmodule

// File: tb/tb_mem_multi_ch.sv
// tb_mem_multi_ch: randomized + directed self-checking bench against a behavioural memory model
module tb_mem_multi_ch;
  localparam int NCH = 2, DW = 32, DEPTH = 48, AW = 6;
  logic clk, rst;
  logic [NCH-1:0] valid, ready, wr_rd, rvalid;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH*DW/8-1:0] wstrb;
  logic [DW-1:0] rdata;
  logic oob;
  logic inj_perr;
`ifdef MEM_PARITY_EN
  logic perr;
`endif
  mem_multi_ch #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .ready(ready),
    .wr_rd(wr_rd),
    .addr(addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .rvalid(rvalid),
    .oob(oob)
`ifdef MEM_PARITY_EN
    ,
    .inj_perr(inj_perr),
    .perr(perr)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  logic [31:0] mem_m [DEPTH];
  logic inj_m [DEPTH];
  int ptr;
  logic [31:0] erd;
  logic [1:0] pv, pw, rdy_seen;
  logic [5:0] pa [2];
  logic [31:0] pd [2];
  logic [3:0] ps [2];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int j = 0; j < DEPTH; j++) begin
      mem_m[j] = '0;
      inj_m[j] = 1'b0;
    end
    ptr = 0;
    erd = '0;
    pv = '0;
  endtask
  task automatic req(int ch, logic w, logic [5:0] ad, logic [31:0] dd, logic [3:0] ss);
    pv[ch] = 1'b1;
    pw[ch] = w;
    pa[ch] = ad;
    pd[ch] = dd;
    ps[ch] = ss;
  endtask
  // One clock: present pending requests, check grant, then check read return against the model.
  task automatic step();
    int g;
    logic [1:0] erv;
    logic eoob, eperr;
    valid = pv;
    wr_rd = pw;
    for (int i = 0; i < NCH; i++) begin
      addr[i*AW +: AW] = pa[i];
      wdata[i*DW +: DW] = pd[i];
      wstrb[i*4 +: 4] = ps[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) if (g < 0 && pv[(ptr + k) % NCH]) g = (ptr + k) % NCH;
    rdy_seen = ready;
    chk("ready", ready, g < 0 ? 2'b00 : 2'(1 << g));
    @(posedge clk);
    #1;
    erv = '0;
    eoob = 1'b0;
    eperr = 1'b0;
    if (g >= 0) begin
      if (pa[g] >= DEPTH) eoob = 1'b1;
      else if (pw[g] && ps[g] != 0) begin
        for (int b = 0; b < 4; b++) if (ps[g][b]) mem_m[pa[g]][b*8 +: 8] = pd[g][b*8 +: 8];
        inj_m[pa[g]] = inj_perr;
      end
      if (!pw[g]) begin
        erv = 2'(1 << g);
        erd = pa[g] < DEPTH ? mem_m[pa[g]] : 32'h0;
        eperr = pa[g] < DEPTH && inj_m[pa[g]];
      end
      ptr = (g + 1) % NCH;
      pv[g] = 1'b0;
    end
    chk("rvalid", rvalid, erv);
    chk("rdata", rdata, erd);
    chk("oob", oob, eoob);
`ifdef MEM_PARITY_EN
    chk("perr", perr, eperr);
`endif
    valid = '0;
  endtask
  task automatic do_reset(int n);
    valid = 2'b11;
    wr_rd = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_ready", ready, 2'b00);
    chk("rst_rvalid", rvalid, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_oob", oob, 1'b0);
    repeat (n) @(posedge clk);
    #1;
    chk("rst_ready_hold", ready, 2'b00);
    chk("rst_rvalid_hold", rvalid, 2'b00);
    rst = 1'b0;
    valid = '0;
    model_clear();
  endtask
  initial begin
    rst = 1'b1;
    valid = '0;
    wr_rd = '0;
    addr = '0;
    wdata = '0;
    wstrb = '0;
    inj_perr = 1'b0;
    pw = '0;
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0;
      pd[i] = '0;
      ps[i] = '0;
    end
    model_clear();
    @(posedge clk);
    #1;
    do_reset(2);
    req(0, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
    step();
    req(1, 1'b0, 6'd5, 32'h0, 4'h0);
    step();
    chk("wr_rd_data", rdata, 32'hDEAD_BEEF);
    chk("wr_rd_owner", rvalid, 2'b10);
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      req(0, 1'b0, 6'(k), 32'h0, 4'h0);
      req(1, 1'b0, 6'(k + 8), 32'h0, 4'h0);
      step();
      chk("alternate", rdy_seen, (k % 2) ? 2'b10 : 2'b01);
    end
    pv = '0;
    req(0, 1'b1, 6'd7, 32'h1122_3344, 4'hF);
    step();
    req(0, 1'b1, 6'd7, 32'hAAAA_AAAA, 4'h2);
    step();
    req(1, 1'b0, 6'd7, 32'h0, 4'h0);
    step();
    chk("strobe_merge", rdata, 32'h1122_AA44);
    req(1, 1'b1, 6'd7, 32'hFFFF_FFFF, 4'h0);
    step();
    req(0, 1'b0, 6'd7, 32'h0, 4'h0);
    step();
    chk("zero_strobe", rdata, 32'h1122_AA44);
    req(0, 1'b1, 6'd2, 32'h0000_0055, 4'hF);
    step();
    req(1, 1'b0, 6'd50, 32'h0, 4'h0);
    step();
    chk("oob_rd_data", rdata, 32'h0);
    chk("oob_rd_pulse", oob, 1'b1);
    step();
    chk("oob_one_shot", oob, 1'b0);
    req(0, 1'b1, 6'd50, 32'h9999_9999, 4'hF);
    step();
    req(0, 1'b0, 6'd2, 32'h0, 4'h0);
    step();
    chk("oob_wr_dropped", rdata, 32'h0000_0055);
    req(1, 1'b1, 6'd3, 32'h1234_5678, 4'hF);
    step();
    req(0, 1'b0, 6'd3, 32'h0, 4'h0);
    do_reset(2);
    req(0, 1'b0, 6'd3, 32'h0, 4'h0);
    step();
    chk("post_rst_rd", rdata, 32'h0);
    chk("post_rst_rvalid", rvalid, 2'b01);
`ifdef MEM_PARITY_EN
    inj_perr = 1'b1;
    req(0, 1'b1, 6'd9, 32'h0F0F_0001, 4'hF);
    step();
    inj_perr = 1'b0;
    req(1, 1'b0, 6'd9, 32'h0, 4'h0);
    step();
    chk("perr_set", perr, 1'b1);
    req(0, 1'b1, 6'd9, 32'h0F0F_0001, 4'hF);
    step();
    req(1, 1'b0, 6'd9, 32'h0, 4'h0);
    step();
    chk("perr_clear", perr, 1'b0);
`endif
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pv[i] && $urandom_range(0, 3) != 0) begin
          req(i, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 6'($urandom_range(48, 63)) :
              ($urandom_range(0, 3) == 0) ? 6'($urandom_range(40, 47)) : 6'($urandom_range(0, 7)),
              $urandom, 4'($urandom_range(0, 15)));
        end
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
